// File: rtl/dense_step_sequencer.sv
// dense_step_sequencer: paces the fully-connected layer datapath.
// A start command latches step period D, input count N and neuron count M.
// For each neuron the block emits a bias-load pulse, then N step strobes
// spaced D cycles apart, then a neuron-done pulse. A done pulse closes the layer.
// Optional build macro STEP_CLK_OUT_EN adds a legacy duty-cycled step_clk output.
module dense_step_sequencer #(
   parameter int DIV_W       = 8,
   parameter int IN_W        = 10,
   parameter int NEU_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clock_in,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] div_cfg,
   input  logic [IN_W-1:0]  n_inputs,
   input  logic [NEU_W-1:0] n_neurons,
   input  logic             hold,
   output logic             busy,
   output logic             step,
   output logic [IN_W-1:0]  in_idx,
   output logic [NEU_W-1:0] neu_idx,
   output logic             bias_ld,
   output logic             neuron_done,
   output logic             done,
   output logic             cfg_err
`ifdef STEP_CLK_OUT_EN
   ,
   output logic             step_clk
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NDONE, S_DONE} state_t;

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   state_t           state_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] phase_q;
   logic [IN_W-1:0]  n_q;
   logic [NEU_W-1:0] m_q;
   logic [IN_W-1:0]  in_idx_q;
   logic [NEU_W-1:0] neu_idx_q;
   logic             busy_q;
   logic             bias_ld_q;
   logic             neuron_done_q;
   logic             done_q;
   logic             cfg_err_q;

   logic phase_last;
   logic in_last;
   logic neu_last;

   assign phase_last = (phase_q == div_q - DIV_W'(1));
   assign in_last    = (in_idx_q == n_q - IN_W'(1));
   assign neu_last   = (neu_idx_q == m_q - NEU_W'(1));

   // NOTE: step must react to hold in the same cycle, so it is decoded from
   // registered state rather than registered itself; all other outputs are flops.
   assign step        = (state_q == S_RUN) && phase_last && !hold;
   assign busy        = busy_q;
   assign in_idx      = in_idx_q;
   assign neu_idx     = neu_idx_q;
   assign bias_ld     = bias_ld_q;
   assign neuron_done = neuron_done_q;
   assign done        = done_q;
   assign cfg_err     = cfg_err_q;

   // Layer FSM: state, counters and registered output pulses.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         div_q         <= '0;
         phase_q       <= '0;
         n_q           <= '0;
         m_q           <= '0;
         in_idx_q      <= '0;
         neu_idx_q     <= '0;
         busy_q        <= 1'b0;
         bias_ld_q     <= 1'b0;
         neuron_done_q <= 1'b0;
         done_q        <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         bias_ld_q     <= 1'b0;
         neuron_done_q <= 1'b0;
         done_q        <= 1'b0;
         cfg_err_q     <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  div_q <= (div_cfg == '0) ? DEF_DIV : div_cfg;
                  n_q   <= n_inputs;
                  m_q   <= n_neurons;
                  if (n_inputs == '0 || n_neurons == '0) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     state_q   <= S_LOAD;
                     neu_idx_q <= '0;
                     in_idx_q  <= '0;
                     phase_q   <= '0;
                     busy_q    <= 1'b1;
                     bias_ld_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               phase_q  <= '0;
               in_idx_q <= '0;
               state_q  <= S_RUN;
            end
            S_RUN: begin
               if (!hold) begin
                  if (phase_last) begin
                     phase_q <= '0;
                     if (in_last) begin
                        state_q       <= S_NDONE;
                        neuron_done_q <= 1'b1;
                     end else begin
                        in_idx_q <= in_idx_q + IN_W'(1);
                     end
                  end else begin
                     phase_q <= phase_q + DIV_W'(1);
                  end
               end
            end
            S_NDONE: begin
               if (neu_last) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  neu_idx_q <= neu_idx_q + NEU_W'(1);
                  in_idx_q  <= '0;
                  state_q   <= S_LOAD;
                  bias_ld_q <= 1'b1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef STEP_CLK_OUT_EN
   logic [DIV_W-1:0] quarter;
   logic             step_clk_d;
   logic             step_clk_q;

   assign quarter  = (div_q < DIV_W'(4)) ? DIV_W'(1) : (div_q >> 2);
   assign step_clk = step_clk_q;

   // Next step_clk value from the phase the FSM will hold in the next cycle.
   always_comb begin
      step_clk_d = 1'b0;
      unique case (state_q)
         S_LOAD: step_clk_d = 1'b1;
         S_RUN: begin
            if (hold)            step_clk_d = step_clk_q;
            else if (phase_last) step_clk_d = !in_last;
            else                 step_clk_d = ((phase_q + DIV_W'(1)) < quarter);
         end
         default: step_clk_d = 1'b0;
      endcase
   end

   // Registered legacy step clock.
   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) step_clk_q <= 1'b0;
      else      step_clk_q <= step_clk_d;
   end
`endif

endmodule

// File: tb/tb_dense_step_sequencer.sv
// Self-checking bench for dense_step_sequencer. The reference model expands
// each accepted layer into a timeline of cycle kinds (LOAD, D*N RUN cycles,
// NDONE per neuron, then DONE); a RUN slot with hold high repeats in place.
module tb_dense_step_sequencer;

   localparam int DIV_W = 8;
   localparam int IN_W  = 10;
   localparam int NEU_W = 8;

   localparam int K_LOAD  = 0;
   localparam int K_RUN   = 1;
   localparam int K_NDONE = 2;
   localparam int K_DONE  = 3;

   typedef struct {
      int kind;
      int in_i;
      int neu;
      int phase;
   } ev_t;

   logic             clock_in = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [DIV_W-1:0] div_cfg = '0;
   logic [IN_W-1:0]  n_inputs = '0;
   logic [NEU_W-1:0] n_neurons = '0;
   logic             hold = 1'b0;
   logic             busy, step, bias_ld, neuron_done, done, cfg_err;
   logic [IN_W-1:0]  in_idx;
   logic [NEU_W-1:0] neu_idx;
`ifdef STEP_CLK_OUT_EN
   logic             step_clk;
`endif

   dense_step_sequencer #(.DIV_W(DIV_W), .IN_W(IN_W), .NEU_W(NEU_W), .DEFAULT_DIV(4)) dut (
      .clock_in   (clock_in),
      .rst        (rst),
      .start      (start),
      .div_cfg    (div_cfg),
      .n_inputs   (n_inputs),
      .n_neurons  (n_neurons),
      .hold       (hold),
      .busy       (busy),
      .step       (step),
      .in_idx     (in_idx),
      .neu_idx    (neu_idx),
      .bias_ld    (bias_ld),
      .neuron_done(neuron_done),
      .done       (done),
      .cfg_err    (cfg_err)
`ifdef STEP_CLK_OUT_EN
      ,
      .step_clk   (step_clk)
`endif
   );

   always #5 clock_in = ~clock_in;

   int  compared = 0;
   int  mismatched = 0;
   ev_t tl[$];
   int  d_m, n_m, m_m;
   bit  err_pend;
   int  cyc = 0;
   int  t0;
   int  holds;
   int  rand_hold_pct = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   task automatic build(input int d, input int n, input int m);
      ev_t e;
      for (int j = 0; j < m; j++) begin
         e = '{K_LOAD, 0, j, 0};
         tl.push_back(e);
         for (int i = 0; i < n; i++)
            for (int p = 0; p < d; p++) begin
               e = '{K_RUN, i, j, p};
               tl.push_back(e);
            end
         e = '{K_NDONE, 0, j, 0};
         tl.push_back(e);
      end
      e = '{K_DONE, 0, m - 1, 0};
      tl.push_back(e);
   endtask

   // One clock cycle: inputs already set; check at negedge, advance the model.
   task automatic cycle();
      ev_t e;
      bit  act;
      int  x_busy, x_step, x_bias, x_nd, x_done, x_sclk;
      @(negedge clock_in);
      act = (tl.size() > 0);
      x_busy = act; x_step = 0; x_bias = 0; x_nd = 0; x_done = 0; x_sclk = 0;
      e = '{0, 0, 0, 0};
      if (act) begin
         e = tl[0];
         case (e.kind)
            K_LOAD:  x_bias = 1;
            K_RUN: begin
               x_step = (e.phase == d_m - 1 && !hold) ? 1 : 0;
               x_sclk = (e.phase < ((d_m / 4 > 1) ? d_m / 4 : 1)) ? 1 : 0;
            end
            K_NDONE: x_nd = 1;
            default: x_done = 1;
         endcase
      end
      check("busy", 32'(busy), 32'(x_busy));
      check("step", 32'(step), 32'(x_step));
      check("bias_ld", 32'(bias_ld), 32'(x_bias));
      check("neuron_done", 32'(neuron_done), 32'(x_nd));
      check("done", 32'(done), 32'(x_done));
      check("cfg_err", 32'(cfg_err), 32'(err_pend));
`ifdef STEP_CLK_OUT_EN
      check("step_clk", 32'(step_clk), 32'(x_sclk));
`endif
      if (act) check("neu_idx", 32'(neu_idx), 32'(e.neu));
      if (x_step) check("in_idx", 32'(in_idx), 32'(e.in_i));
      if (x_done) check("latency", 32'(cyc - t0), 32'(m_m * (n_m * d_m + 2) + 1 + holds));
      err_pend = 0;
      if (act) begin
         if (e.kind == K_RUN && hold) holds++;
         else void'(tl.pop_front());
      end else if (start) begin
         if (n_inputs == 0 || n_neurons == 0) err_pend = 1;
         else begin
            d_m = (div_cfg == 0) ? 4 : int'(div_cfg);
            n_m = int'(n_inputs);
            m_m = int'(n_neurons);
            t0 = cyc;
            holds = 0;
            build(d_m, n_m, m_m);
         end
      end
      @(posedge clock_in);
      #1;
      cyc++;
   endtask

   task automatic launch(input int d, input int n, input int m);
      div_cfg = DIV_W'(d); n_inputs = IN_W'(n); n_neurons = NEU_W'(m);
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // Run until the model goes idle; config inputs are scrambled meanwhile.
   task automatic drain(input bit scramble);
      int k;
      for (k = 0; k < 3000 && tl.size() > 0; k++) begin
         hold = ($urandom_range(99) < rand_hold_pct);
         if (scramble) begin
            div_cfg = DIV_W'($urandom); n_inputs = IN_W'($urandom); n_neurons = NEU_W'($urandom);
         end
         cycle();
      end
      hold = 1'b0;
      check("drain_bound", 32'(tl.size()), 32'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      // Reset state.
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_step", 32'(step), 32'd0);
      check("rst_in_idx", 32'(in_idx), 32'd0);
      check("rst_neu_idx", 32'(neu_idx), 32'd0);
      @(posedge clock_in); #1;
      rst = 1'b1;
      idle_cycles(2);

      // Basic layer D=4, N=3, M=2.
      launch(4, 3, 2);
      drain(1'b1);
      idle_cycles(2);

      // Minimum period, then default period from div_cfg = 0.
      launch(1, 1, 1);
      drain(1'b0);
      launch(0, 2, 1);
      drain(1'b0);

      // Rejected configurations.
      launch(3, 0, 2);
      idle_cycles(1);
      launch(3, 2, 0);
      idle_cycles(2);

      // Stall: hold high for 3 cycles starting at t0+2.
      launch(2, 2, 1);
      cycle();
      hold = 1'b1;
      idle_cycles(3);
      hold = 1'b0;
      drain(1'b0);

      // Start while busy is ignored.
      launch(3, 2, 2);
      idle_cycles(4);
      start = 1'b1; div_cfg = 8'd1; n_inputs = 10'd1; n_neurons = 8'd1;
      idle_cycles(2);
      start = 1'b0;
      idle_cycles(3);

      // Asynchronous abort mid-RUN.
      #3;
      rst = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_step", 32'(step), 32'd0);
      check("abort_bias", 32'(bias_ld), 32'd0);
      check("abort_nd", 32'(neuron_done), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_neu_idx", 32'(neu_idx), 32'd0);
      check("abort_in_idx", 32'(in_idx), 32'd0);
`ifdef STEP_CLK_OUT_EN
      check("abort_step_clk", 32'(step_clk), 32'd0);
`endif
      tl.delete();
      err_pend = 0;
      @(posedge clock_in); #1;
      rst = 1'b1;
      idle_cycles(2);
      launch(2, 3, 2);
      drain(1'b0);

`ifdef STEP_CLK_OUT_EN
      launch(8, 2, 1);
      drain(1'b0);
      idle_cycles(2);
`endif

      // Randomized layers with random stalls and noisy config inputs.
      rand_hold_pct = 25;
      for (int r = 0; r < 20; r++) begin
         launch($urandom_range(9), $urandom_range(5, 1), $urandom_range(3, 1));
         drain(1'b1);
         idle_cycles($urandom_range(2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
